// File: rtl/cnn_cell_seq_if.sv
// Handshake and data bundle between the neighbourhood fetch logic, the
// sequential CNN cell, and the cell-output buffer.
interface cnn_cell_seq_if #(
  parameter int WIDTH   = 16,
  parameter int SHIFT_W = 4
);
  logic                      start;
  logic                      mode;
  logic        [SHIFT_W-1:0] step_shift;
  logic signed [WIDTH-1:0]   bias_i;
  logic                      clear_state;
  logic                      tap_valid;
  logic                      tap_ready;
  logic signed [WIDTH-1:0]   tap_a;
  logic signed [WIDTH-1:0]   tap_y;
  logic signed [WIDTH-1:0]   tap_b;
  logic signed [WIDTH-1:0]   tap_u;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [WIDTH-1:0]   out_y;
  logic signed [WIDTH-1:0]   state_x;
  logic                      busy;

  modport master (
    output start, mode, step_shift, bias_i, clear_state,
    output tap_valid, tap_a, tap_y, tap_b, tap_u, out_ready,
    input  tap_ready, out_valid, out_y, state_x, busy
  );

  modport slave (
    input  start, mode, step_shift, bias_i, clear_state,
    input  tap_valid, tap_a, tap_y, tap_b, tap_u, out_ready,
    output tap_ready, out_valid, out_y, state_x, busy
  );
endinterface

// File: rtl/cnn_cell_seq.sv
// Sequential CNN cell: streams TAPS (A,Y,B,U) tuples through one MAC pair,
// adds the bias, optionally Euler-integrates the state and saturates the output.
module cnn_cell_seq #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 8,
  parameter int TAPS    = 9,
  parameter int SHIFT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  cnn_cell_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, OUT} state_t;

  // Accumulator is wide enough for 2*TAPS full-scale products; the extra two
  // bits of EW absorb the bias add and the (s - x) difference.
  localparam int AW = 2*WIDTH + $clog2(2*TAPS);
  localparam int EW = AW + 2;
  localparam int CW = $clog2(TAPS + 1);

  localparam logic signed [WIDTH-1:0] X_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] X_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1 << FRAC);
  localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;
  localparam logic        [CW-1:0]    LAST    = CW'(TAPS - 1);

  state_t                    state;
  logic signed [AW-1:0]      acc;
  logic        [CW-1:0]      tap_cnt;
  logic                      mode_r;
  logic        [SHIFT_W-1:0] shift_r;
  logic signed [WIDTH-1:0]   bias_r;
  logic signed [WIDTH-1:0]   x;

  logic signed [2*WIDTH-1:0] prod_a;
  logic signed [2*WIDTH-1:0] prod_b;
  logic signed [AW-1:0]      tap_sum;
  logic signed [EW-1:0]      s_full;
  logic signed [EW-1:0]      x_ext;
  logic signed [EW-1:0]      pre_sat;
  logic signed [WIDTH-1:0]   x_new;
  logic signed [WIDTH-1:0]   y_new;

  assign prod_a  = (2*WIDTH)'(bus.tap_a) * (2*WIDTH)'(bus.tap_y);
  assign prod_b  = (2*WIDTH)'(bus.tap_b) * (2*WIDTH)'(bus.tap_u);
  assign tap_sum = AW'(prod_a) + AW'(prod_b);

  assign bus.state_x = x;

  // NOTE: every variable gets a value on every path through always_comb;
  // a missing else branch would silently infer a latch.
  always_comb begin
    x_ext   = EW'(x);
    s_full  = (EW'(acc) + (EW'(bias_r) <<< FRAC)) >>> FRAC;
    pre_sat = mode_r ? x_ext + ((s_full - x_ext) >>> shift_r) : s_full;

    if (pre_sat > EW'(X_MAX))      x_new = X_MAX;
    else if (pre_sat < EW'(X_MIN)) x_new = X_MIN;
    else                           x_new = pre_sat[WIDTH-1:0];

    if (x_new > ONE)               y_new = ONE;
    else if (x_new < NEG_ONE)      y_new = NEG_ONE;
    else                           y_new = x_new;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      tap_cnt       <= '0;
      mode_r        <= 1'b0;
      shift_r       <= '0;
      bias_r        <= '0;
      x             <= '0;
      bus.out_y     <= '0;
      bus.tap_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // Clearing here lands before any run's FINAL, so a simultaneous
          // start integrates from x = 0.
          if (bus.clear_state) x <= '0;
          if (bus.start) begin
            mode_r        <= bus.mode;
            shift_r       <= bus.step_shift;
            bias_r        <= bus.bias_i;
            acc           <= '0;
            tap_cnt       <= '0;
            bus.tap_ready <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= ACCUM;
          end
        end

        ACCUM: begin
          if (bus.tap_valid && bus.tap_ready) begin
            acc     <= acc + tap_sum;
            tap_cnt <= tap_cnt + 1'b1;
            if (tap_cnt == LAST) begin
              bus.tap_ready <= 1'b0;
              state         <= FINAL;
            end
          end
        end

        FINAL: begin
          x             <= x_new;
          bus.out_y     <= y_new;
          bus.out_valid <= 1'b1;
          state         <= OUT;
        end

        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_cell_seq.sv
// Randomised scoreboard bench for cnn_cell_seq: the driver pushes expected
// results from an arithmetic reference model, a monitor pops them on output handshakes.
module tb_cnn_cell_seq;
  localparam int WIDTH   = 16;
  localparam int FRAC    = 8;
  localparam int TAPS    = 9;
  localparam int SHIFT_W = 4;
  localparam longint ONE = 256;

  typedef struct {
    longint y;
    longint x;
  } exp_t;

  logic clk;
  logic rst_n;
  cnn_cell_seq_if #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) bus ();

  cnn_cell_seq #(.WIDTH(WIDTH), .FRAC(FRAC), .TAPS(TAPS), .SHIFT_W(SHIFT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_runs   = 0;
  int     n_outs   = 0;
  exp_t   sb_q[$];
  longint x_model  = 0;
  int     ta[TAPS], ty[TAPS], tb_c[TAPS], tu[TAPS];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Reference: real-valued CNN update with floor rounding, then saturation.
  task automatic model(input bit m, input int sh, input longint bias, input longint sum,
                       output exp_t e);
    longint s, xn;
    s = floor_div(sum + bias * ONE, ONE);
    if (m == 1'b0) xn = s;
    else           xn = x_model + floor_div(s - x_model, longint'(1) << sh);
    xn      = clamp(xn, -32768, 32767);
    x_model = xn;
    e.x     = xn;
    e.y     = clamp(xn, -ONE, ONE);
  endtask

  // Monitor: a handshake completes at the next rising edge when both are high now.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        n_outs++;
        check("out_has_expected", longint'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("out_y", bus.out_y, e.y);
          check("state_x", bus.state_x, e.x);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.start = 1'b0; bus.mode = 1'b0; bus.step_shift = '0; bus.bias_i = '0;
    bus.clear_state = 1'b0; bus.tap_valid = 1'b0;
    bus.tap_a = '0; bus.tap_y = '0; bus.tap_b = '0; bus.tap_u = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic zero_taps();
    for (int i = 0; i < TAPS; i++) begin
      ta[i] = 0; ty[i] = 0; tb_c[i] = 0; tu[i] = 0;
    end
  endtask

  // Issue one complete run; gap_pct inserts tap_valid bubbles, stall holds out_ready low,
  // noise pulses start while the cell is busy.
  task automatic run(input bit m, input int sh, input int bias, input bit clr,
                     input int gap_pct, input int stall, input bit noise);
    longint sum = 0;
    exp_t   e;
    int     guard;
    logic signed [WIDTH-1:0] y_hold;
    for (int i = 0; i < TAPS; i++)
      sum += longint'(ta[i]) * ty[i] + longint'(tb_c[i]) * tu[i];
    if (clr) x_model = 0;
    model(m, sh, bias, sum, e);
    sb_q.push_back(e);
    n_runs++;

    bus.out_ready   = (stall == 0);
    bus.mode        = m;
    bus.step_shift  = SHIFT_W'(sh);
    bus.bias_i      = WIDTH'(bias);
    bus.clear_state = clr;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.clear_state = 1'b0;
    check("busy_after_start", bus.busy, 1);

    for (int i = 0; i < TAPS; i++) begin
      for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
        bus.tap_valid = 1'b0;
        bus.start     = noise;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
      bus.tap_valid = 1'b1;
      bus.tap_a = WIDTH'(ta[i]); bus.tap_y = WIDTH'(ty[i]);
      bus.tap_b = WIDTH'(tb_c[i]); bus.tap_u = WIDTH'(tu[i]);
      guard = 0;
      while (!bus.tap_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 50) begin
        check("tap_ready_timeout", guard, 0);
        bus.tap_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.tap_valid = 1'b0;

    check("final_out_valid_low", bus.out_valid, 0);
    check("final_tap_ready_low", bus.tap_ready, 0);
    @(posedge clk); #1;
    check("latency_out_valid", bus.out_valid, 1);
    check("out_tap_ready_low", bus.tap_ready, 0);

    if (stall > 0) begin
      y_hold = bus.out_y;
      repeat (stall) begin
        bus.start = noise;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("stall_out_y_stable", bus.out_y, y_hold);
        check("stall_out_valid_held", bus.out_valid, 1);
      end
      bus.out_ready = 1'b1;
    end

    guard = 0;
    while (bus.busy && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("run_completed", bus.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    zero_taps();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_y", bus.out_y, 0);
    check("rst_state_x", bus.state_x, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_tap_ready", bus.tap_ready, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero taps, bias 0.5.
    run(1'b0, 0, 128, 1'b0, 0, 0, 1'b0);

    // 1.0*1.0 nine times: saturated positive, then negative.
    for (int i = 0; i < TAPS; i++) begin ta[i] = 256; ty[i] = 256; end
    run(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < TAPS; i++) ta[i] = -256;
    run(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);

    // Euler integration toward s = 200 with h = 1/2, starting from a cleared state.
    zero_taps();
    ta[0] = 200; ty[0] = 256;
    run(1'b1, 1, 0, 1'b1, 0, 0, 1'b0);
    run(1'b1, 1, 0, 1'b0, 0, 0, 1'b0);
    run(1'b1, 1, 0, 1'b0, 0, 0, 1'b0);
    bus.clear_state = 1'b1;
    @(posedge clk); #1;
    bus.clear_state = 1'b0;
    x_model = 0;
    check("clear_state_x", bus.state_x, 0);
    check("clear_keeps_out_y", bus.out_y, 175);

    // Bubbly taps, 5-cycle back-pressure and stray start pulses.
    for (int i = 0; i < TAPS; i++) begin ta[i] = 16 * i; ty[i] = 64; tb_c[i] = -8; tu[i] = 100; end
    run(1'b0, 0, -20, 1'b0, 50, 5, 1'b1);

    // Mid-run reset after four taps.
    bus.mode = 1'b0; bus.bias_i = 16'sd100; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.tap_valid = 1'b1; bus.tap_a = 16'sd256; bus.tap_y = 16'sd256;
    repeat (4) begin @(posedge clk); #1; end
    bus.tap_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    x_model = 0;
    check("midrst_out_y", bus.out_y, 0);
    check("midrst_state_x", bus.state_x, 0);
    check("midrst_tap_ready", bus.tap_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    zero_taps();
    run(1'b0, 0, 64, 1'b0, 0, 0, 1'b0);

    // Randomised runs across modes, shifts, biases and operand ranges.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < TAPS; i++) begin
        if (r % 3 == 0) begin
          ta[i] = int'($urandom_range(0, 65535)) - 32768;
          ty[i] = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          ta[i] = int'($urandom_range(0, 1023)) - 512;
          ty[i] = int'($urandom_range(0, 512)) - 256;
        end
        tb_c[i] = int'($urandom_range(0, 1023)) - 512;
        tu[i]   = int'($urandom_range(0, 512)) - 256;
      end
      run(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 65535)) - 32768, ($urandom_range(0, 4) == 0),
          int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    check("handshakes_per_run", n_outs, n_runs);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
